can_error_monitor: RTL and testbench

//  Parametrised CAN error-frame monitor; successor to the fixed 6-dominant/8-recessive detector.

---
 rtl/can_error_monitor_if.sv | 27 ++
 rtl/can_error_monitor.sv | 185 ++++++++++++++++++
 tb/tb_can_error_monitor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/can_error_monitor_if.sv
// Bus-side signals of the CAN error-frame monitor: sampled RX level and strobes in,
// error-frame status out. Master is the bit-timing/RX side, slave is the monitor.
interface can_error_monitor_if #(
    parameter int LEN_W = 6,
    parameter int CNT_W = 16
);
    logic             dIn;
    logic             samplePulse;
    logic             rateSelector;
    logic             clrCount;
    logic             errorFrame;
    logic             errorStart;
    logic             errorEnd;
    logic [LEN_W-1:0] flagLen;
    logic [CNT_W-1:0] errCount;
    logic             stuckDominant;

    modport master (
        output dIn, samplePulse, rateSelector, clrCount,
        input  errorFrame, errorStart, errorEnd, flagLen, errCount, stuckDominant
    );

    modport slave (
        input  dIn, samplePulse, rateSelector, clrCount,
        output errorFrame, errorStart, errorEnd, flagLen, errCount, stuckDominant
    );
endinterface

// File: rtl/can_error_monitor.sv
// CAN error-frame monitor: builds one bit value per bit time (single or 2-of-3 sampling),
// then tracks error flag / delimiter and reports events, flag length, frame count and stuck bus.
//
// bit FSM  | meaning
// B_IDLE   | waiting for first sample of a bit
// B_S1     | triple mode, first sample taken
// B_S2     | triple mode, second sample taken
// B_DONE   | bit value valid for one cycle
//
// main FSM | meaning
// IDLE     | counting dominant run towards an error flag
// FLAG     | inside a dominant error flag
// DELIM    | counting recessive bits of the error delimiter
module can_error_monitor #(
    parameter int DOM_THRESH = 6,
    parameter int DELIM_LEN  = 8,
    parameter int STUCK_LEN  = 32,
    parameter int LEN_W      = 6,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               resetN,
    can_error_monitor_if.slave bus
);

    typedef enum logic [1:0] {B_IDLE, B_S1, B_S2, B_DONE} bit_state_t;
    typedef enum logic [1:0] {IDLE, FLAG, DELIM} mon_state_t;

    localparam logic [LEN_W-1:0] DOM_T   = LEN_W'(DOM_THRESH);
    localparam logic [LEN_W-1:0] DELIM_T = LEN_W'(DELIM_LEN);
    localparam logic [LEN_W-1:0] STUCK_T = LEN_W'(STUCK_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    bit_state_t       bit_state;
    logic             rate_q;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             bit_valid;
    logic             bit_val;

    mon_state_t       mon_state;
    logic [LEN_W-1:0] run;
    logic [LEN_W-1:0] run_inc;
    logic [LEN_W-1:0] flag_len;
    logic [LEN_W-1:0] flag_inc;
    logic [CNT_W-1:0] err_count;
    logic             error_frame;
    logic             error_start;
    logic             error_end;
    logic             stuck_dominant;
    logic             count_inc;

    // Rate is latched on the first sample so a mid-bit change of rateSelector cannot split a bit.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            bit_state <= B_IDLE;
            rate_q    <= 1'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
        end else begin
            case (bit_state)
                B_IDLE: begin
                    if (bus.samplePulse) begin
                        rate_q    <= bus.rateSelector;
                        s0        <= bus.dIn;
                        bit_state <= bus.rateSelector ? B_S1 : B_DONE;
                    end
                end
                B_S1: begin
                    if (bus.samplePulse) begin
                        s1        <= bus.dIn;
                        bit_state <= B_S2;
                    end
                end
                B_S2: begin
                    if (bus.samplePulse) begin
                        s2        <= bus.dIn;
                        bit_state <= B_DONE;
                    end
                end
                B_DONE:  bit_state <= B_IDLE;
                default: bit_state <= B_IDLE;
            endcase
        end
    end

    assign bit_valid = (bit_state == B_DONE);
    assign bit_val   = rate_q ? ((s0 & s1) | (s0 & s2) | (s1 & s2)) : s0;

    assign run_inc   = run + LEN_W'(1);
    assign flag_inc  = (flag_len == LEN_MAX) ? flag_len : flag_len + LEN_W'(1);
    assign count_inc = bit_valid && (mon_state == IDLE) && !bit_val && (run_inc == DOM_T);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            mon_state      <= IDLE;
            run            <= '0;
            flag_len       <= '0;
            error_frame    <= 1'b0;
            error_start    <= 1'b0;
            error_end      <= 1'b0;
            stuck_dominant <= 1'b0;
        end else begin
            error_start <= 1'b0;
            error_end   <= 1'b0;
            if (bit_valid) begin
                case (mon_state)
                    IDLE: begin
                        if (bit_val) begin
                            run <= '0;
                        end else if (run_inc == DOM_T) begin
                            mon_state   <= FLAG;
                            run         <= '0;
                            flag_len    <= DOM_T;
                            error_start <= 1'b1;
                            error_frame <= 1'b1;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    FLAG: begin
                        if (!bit_val) begin
                            flag_len <= flag_inc;
                            if (flag_inc >= STUCK_T)
                                stuck_dominant <= 1'b1;
                        end else begin
                            stuck_dominant <= 1'b0;
                            // A one-bit delimiter is already complete on its first recessive bit.
                            if (DELIM_LEN == 1) begin
                                mon_state   <= IDLE;
                                run         <= '0;
                                error_end   <= 1'b1;
                                error_frame <= 1'b0;
                            end else begin
                                mon_state <= DELIM;
                                run       <= LEN_W'(1);
                            end
                        end
                    end
                    DELIM: begin
                        if (!bit_val) begin
                            mon_state <= FLAG;
                            run       <= '0;
                            flag_len  <= LEN_W'(1);
                        end else if (run_inc == DELIM_T) begin
                            mon_state   <= IDLE;
                            run         <= '0;
                            error_end   <= 1'b1;
                            error_frame <= 1'b0;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    default: begin
                        mon_state   <= IDLE;
                        run         <= '0;
                        error_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clear wins, but a frame counted in the same cycle still survives the clear.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            err_count <= '0;
        end else if (bus.clrCount) begin
            err_count <= count_inc ? CNT_W'(1) : '0;
        end else if (count_inc && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

    assign bus.errorFrame    = error_frame;
    assign bus.errorStart    = error_start;
    assign bus.errorEnd      = error_end;
    assign bus.flagLen       = flag_len;
    assign bus.errCount      = err_count;
    assign bus.stuckDominant = stuck_dominant;

endmodule

// File: tb/tb_can_error_monitor.sv
// Bench for can_error_monitor: table of per-bit vectors with hand-computed results,
// plus sequences for latency, reset mid-flag and counter saturation/clear.
module tb_can_error_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n_a = 1'b0;
    logic reset_n_b = 1'b0;
    logic d_in      = 1'b1;
    logic pulse_s   = 1'b0;
    logic rate      = 1'b0;
    logic clr_a     = 1'b0;
    logic clr_b     = 1'b0;

    can_error_monitor_if #(.LEN_W(6), .CNT_W(16)) bus_a ();
    can_error_monitor_if #(.LEN_W(6), .CNT_W(2))  bus_b ();

    assign bus_a.dIn          = d_in;
    assign bus_a.samplePulse  = pulse_s;
    assign bus_a.rateSelector = rate;
    assign bus_a.clrCount     = clr_a;
    assign bus_b.dIn          = d_in;
    assign bus_b.samplePulse  = pulse_s;
    assign bus_b.rateSelector = rate;
    assign bus_b.clrCount     = clr_b;

    can_error_monitor #(.DOM_THRESH(6), .DELIM_LEN(8), .STUCK_LEN(32), .LEN_W(6), .CNT_W(16))
        dut_a (.clk(clk), .resetN(reset_n_a), .bus(bus_a));
    can_error_monitor #(.DOM_THRESH(6), .DELIM_LEN(8), .STUCK_LEN(32), .LEN_W(6), .CNT_W(2))
        dut_b (.clk(clk), .resetN(reset_n_b), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit rate;
        bit s0, s1, s2;
        bit frame, start, fin, stuck;
        int fl;
        int cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit a, bit b, bit c, bit fr, bit st, bit en, bit sk,
                                int fl, int cnt);
        vec_t v;
        v.rate = r; v.s0 = a; v.s1 = b; v.s2 = c;
        v.frame = fr; v.start = st; v.fin = en; v.stuck = sk;
        v.fl = fl; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    function automatic void add_dom(bit fr, bit st, bit en, bit sk, int fl, int cnt);
        add(1'b0, 1'b0, 1'b0, 1'b0, fr, st, en, sk, fl, cnt);
    endfunction

    function automatic void add_rec(bit fr, bit st, bit en, bit sk, int fl, int cnt);
        add(1'b0, 1'b1, 1'b1, 1'b1, fr, st, en, sk, fl, cnt);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulse(input logic v);
        @(negedge clk);
        d_in    = v;
        pulse_s = 1'b1;
        @(negedge clk);
        pulse_s = 1'b0;
    endtask

    // Returns at the negedge where the monitor's outputs for this bit are visible.
    task automatic send_bit(input bit r, input bit a, input bit b, input bit c);
        rate = r;
        pulse(a);
        if (r) begin
            pulse(b);
            pulse(c);
        end
        @(negedge clk);
    endtask

    task automatic frame_b();
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 5 dominant then recessive: below threshold
        for (int i = 0; i < 5; i++) add_dom(0, 0, 0, 0, 0, 0);
        add_rec(0, 0, 0, 0, 0, 0);
        // triple sampling, majority recessive
        for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        // triple sampling, majority dominant -> flag on 6th bit
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1, 0, 0, 6, 1);
        for (int i = 0; i < 7; i++) add_rec(1, 0, 0, 0, 6, 1);
        add_rec(0, 0, 1, 0, 6, 1);
        // 12 dominant, 8 recessive; flagLen held from previous flag until next start
        for (int i = 0; i < 5; i++) add_dom(0, 0, 0, 0, 6, 1);
        add_dom(1, 1, 0, 0, 6, 2);
        for (int k = 7; k <= 12; k++) add_dom(1, 0, 0, 0, k, 2);
        for (int i = 0; i < 7; i++) add_rec(1, 0, 0, 0, 12, 2);
        add_rec(0, 0, 1, 0, 12, 2);
        // superposed flag: 3 recessive then dominant -> FLAG, flagLen 1, no new start
        for (int i = 0; i < 5; i++) add_dom(0, 0, 0, 0, 12, 2);
        add_dom(1, 1, 0, 0, 6, 3);
        for (int i = 0; i < 3; i++) add_rec(1, 0, 0, 0, 6, 3);
        add_dom(1, 0, 0, 0, 1, 3);
        for (int i = 0; i < 7; i++) add_rec(1, 0, 0, 0, 1, 3);
        add_rec(0, 0, 1, 0, 1, 3);
        // long flag: stuck at bit 32, flagLen saturates at 63, first recessive clears stuck
        for (int i = 0; i < 5; i++) add_dom(0, 0, 0, 0, 1, 3);
        add_dom(1, 1, 0, 0, 6, 4);
        for (int k = 7; k <= 70; k++) add_dom(1, 0, 0, (k >= 32), (k > 63) ? 63 : k, 4);
        add_rec(1, 0, 0, 0, 63, 4);
        for (int i = 0; i < 6; i++) add_rec(1, 0, 0, 0, 63, 4);
        add_rec(0, 0, 1, 0, 63, 4);

        repeat (3) @(negedge clk);
        check("reset errorFrame", int'(bus_a.errorFrame), 0);
        check("reset errorStart", int'(bus_a.errorStart), 0);
        check("reset errorEnd", int'(bus_a.errorEnd), 0);
        check("reset flagLen", int'(bus_a.flagLen), 0);
        check("reset errCount", int'(bus_a.errCount), 0);
        check("reset stuck", int'(bus_a.stuckDominant), 0);
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            send_bit(vecs[i].rate, vecs[i].s0, vecs[i].s1, vecs[i].s2);
            check($sformatf("vec%0d errorFrame", i), int'(bus_a.errorFrame), int'(vecs[i].frame));
            check($sformatf("vec%0d errorStart", i), int'(bus_a.errorStart), int'(vecs[i].start));
            check($sformatf("vec%0d errorEnd", i), int'(bus_a.errorEnd), int'(vecs[i].fin));
            check($sformatf("vec%0d stuck", i), int'(bus_a.stuckDominant), int'(vecs[i].stuck));
            check($sformatf("vec%0d flagLen", i), int'(bus_a.flagLen), vecs[i].fl);
            check($sformatf("vec%0d errCount", i), int'(bus_a.errCount), vecs[i].cnt);
        end

        // reset in the middle of a flag with flagLen = 8
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("midflag flagLen", int'(bus_a.flagLen), 8);
        check("midflag errorFrame", int'(bus_a.errorFrame), 1);
        reset_n_a = 1'b0;
        @(negedge clk);
        reset_n_a = 1'b1;
        check("after reset errorFrame", int'(bus_a.errorFrame), 0);
        check("after reset flagLen", int'(bus_a.flagLen), 0);
        check("after reset errCount", int'(bus_a.errCount), 0);
        check("after reset stuck", int'(bus_a.stuckDominant), 0);

        // re-detect and measure latency from the final sample strobe
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre-threshold errorFrame", int'(bus_a.errorFrame), 0);
        rate = 1'b0;
        pulse(1'b0);
        check("latency +1 errorFrame", int'(bus_a.errorFrame), 0);
        @(negedge clk);
        check("latency +2 errorFrame", int'(bus_a.errorFrame), 1);
        check("redetect errorStart", int'(bus_a.errorStart), 1);
        check("redetect flagLen", int'(bus_a.flagLen), 6);
        check("redetect errCount", int'(bus_a.errCount), 1);

        // narrow counter: saturation and clear-with-increment
        reset_n_b = 1'b0;
        @(negedge clk);
        reset_n_b = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            frame_b();
            check($sformatf("narrow count frame%0d", f), int'(bus_b.errCount), (f > 3) ? 3 : f);
        end
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        rate = 1'b0;
        pulse(1'b0);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        check("clr with inc errorStart", int'(bus_b.errorStart), 1);
        check("clr with inc errCount", int'(bus_b.errCount), 1);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b1, 1'b1);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        @(negedge clk);
        check("plain clr errCount", int'(bus_b.errCount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
